// File: rtl/krake_uart_tx_sched.sv
// krake_uart_tx_sched: round-robin Wishbone master that shares the krake UART TX among N_REQ byte producers.
// Latency: 10 cycles from the grant decision back to IDLE with 2-cycle acks and an idle UART; each busy poll adds ack + POLL_GAP cycles.
// Backpressure: requesters hold valid until a one-cycle ready pulse; each bus access waits for ack_i, aborting after ACK_TIMEOUT cycles.
module krake_uart_tx_sched #(
  parameter int         N_REQ       = 4,
  parameter logic [4:0] ADR_DATA    = 5'h00,
  parameter logic [4:0] ADR_STATUS  = 5'h01,
  parameter int         ACK_TIMEOUT = 15,
  parameter int         POLL_GAP    = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [2:0]         grant_o,
  output logic               busy_o,
  output logic               err_o,
  input  logic               err_clr_i,
  output logic               stb_o,
  output logic               we_o,
  output logic [4:0]         adr_o,
  output logic [7:0]         dat_o,
  input  logic [7:0]         dat_i,
  input  logic               ack_i
);

  typedef enum logic [2:0] {
    IDLE,
    POLL_RD,
    POLL_WT,
    GAP,
    WR_DAT,
    WR_DAT_WT,
    WR_GO,
    WR_GO_WT
  } state_t;

  localparam int         CNT_MAX = (ACK_TIMEOUT > POLL_GAP) ? ACK_TIMEOUT : POLL_GAP;
  localparam int         CW      = $clog2(CNT_MAX + 1);
  localparam logic [2:0] PTR_RST = 3'(N_REQ - 1);

  state_t        state_q;
  logic [2:0]    ptr_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    byte_q;

  // Requester vectors padded to the 8-requester maximum so a 3-bit index always fits
  logic [7:0]  vld_pad;
  logic [63:0] dat_pad;
  logic        sel_found;
  logic [2:0]  sel_idx;
  logic [3:0]  cand;
  logic        ack_expired;
  logic        gap_done;
  logic        unused_dat;

  assign vld_pad     = 8'(req_valid_i);
  assign dat_pad     = 64'(req_data_i);
  assign busy_o      = (state_q != IDLE);
  // Counter starts at 1 on entering a wait state, so reaching ACK_TIMEOUT-1 without ack
  // means the error becomes visible exactly ACK_TIMEOUT cycles after the strobe
  assign ack_expired = (cnt_q == CW'(ACK_TIMEOUT - 1));
  assign gap_done    = (cnt_q == CW'(POLL_GAP - 1));
  assign unused_dat  = ^dat_i[7:1];

  // Round-robin search: first valid requester starting one past the last grant, wrapping at N_REQ
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    cand      = 4'd0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      if (!sel_found && vld_pad[cand[2:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[2:0];
      end
    end
  end

  // Bus-master FSM: grant, status polling, data and start writes, ack timeout, sticky error
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_RST;
      cnt_q       <= '0;
      byte_q      <= '0;
      req_ready_o <= '0;
      grant_o     <= '0;
      err_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
    end else begin
      stb_o       <= 1'b0;
      req_ready_o <= '0;
      // A timeout set later in this block overrides the clear
      if (err_clr_i) begin
        err_o <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            byte_q      <= dat_pad[{sel_idx, 3'b000} +: 8];
            grant_o     <= sel_idx;
            ptr_q       <= sel_idx;
            req_ready_o <= N_REQ'(1) << sel_idx;
            stb_o       <= 1'b1;
            we_o        <= 1'b0;
            adr_o       <= ADR_STATUS;
            state_q     <= POLL_RD;
          end
        end
        POLL_RD: begin
          cnt_q   <= CW'(1);
          state_q <= POLL_WT;
        end
        POLL_WT: begin
          if (ack_i) begin
            if (dat_i[0]) begin
              stb_o   <= 1'b1;
              we_o    <= 1'b1;
              adr_o   <= ADR_DATA;
              dat_o   <= byte_q;
              state_q <= WR_DAT;
            end else begin
              cnt_q   <= '0;
              state_q <= GAP;
            end
          end else if (ack_expired) begin
            err_o   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (gap_done) begin
            stb_o   <= 1'b1;
            we_o    <= 1'b0;
            adr_o   <= ADR_STATUS;
            state_q <= POLL_RD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WR_DAT: begin
          cnt_q   <= CW'(1);
          state_q <= WR_DAT_WT;
        end
        WR_DAT_WT: begin
          if (ack_i) begin
            stb_o   <= 1'b1;
            we_o    <= 1'b1;
            adr_o   <= ADR_STATUS;
            dat_o   <= 8'h01;
            state_q <= WR_GO;
          end else if (ack_expired) begin
            err_o   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WR_GO: begin
          cnt_q   <= CW'(1);
          state_q <= WR_GO_WT;
        end
        WR_GO_WT: begin
          if (ack_i) begin
            state_q <= IDLE;
          end else if (ack_expired) begin
            err_o   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/krake_uart_tx_sched.md
Name: krake_uart_tx_sched

Overview:
Wishbone bus master that shares the krake UART TX peripheral among N_REQ byte producers. It arbitrates round-robin between requesters. For each granted byte it polls the UART status register until the transmitter is idle, writes the byte to the data register, then writes the start command to the status register. It sits between on-chip producers (debug, trace, command response) and the UART port's slave interface.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADR_DATA, 5'h00, UART data register address
ADR_STATUS, 5'h01, UART status register address; bit0 reads 1 = TX idle; writing 8'h01 starts TX
ACK_TIMEOUT, 15, cycles to wait for ack_i after a strobe before aborting
POLL_GAP, 4, idle cycles between successive status polls

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
req_valid_i  in  N_REQ  requester k has a byte pending; held until its ready pulse
req_data_i  in  8*N_REQ  byte for requester k in bits [8k+7:8k]
req_ready_o  out  N_REQ  one-cycle accept pulse, one-hot
grant_o  out  3  index of the requester currently being served
busy_o  out  1  high whenever the FSM is not in IDLE
err_o  out  1  sticky bus timeout flag
err_clr_i  in  1  clears err_o
stb_o  out  1  bus strobe, one-cycle pulse per access
we_o  out  1  1 = write
adr_o  out  5  bus address
dat_o  out  8  write data
dat_i  in  8  read data
ack_i  in  1  slave acknowledge

Behaviour:
- Reset (async assert, sync deassert) values:
  - req_ready_o=0, grant_o=0, busy_o=0, err_o=0, stb_o=0, we_o=0, adr_o=0, dat_o=0.
  - FSM goes to IDLE; round-robin pointer goes to N_REQ-1, so requester 0 has first priority.
  - Reset mid-transfer abandons the transfer. The byte is lost and is not re-requested.
- FSM states: IDLE, POLL_RD, POLL_WT, GAP, WR_DAT, WR_DAT_WT, WR_GO, WR_GO_WT.
- IDLE:
  - If any req_valid_i is high, grant the first valid index searching upward from pointer+1, wrapping at N_REQ.
  - At the same edge: latch that requester's byte, set grant_o, update the pointer to the granted index, go to POLL_RD.
  - req_ready_o[grant] is high for exactly the next cycle. The requester must drop or advance valid at the following edge.
- POLL_RD: drive stb_o=1, we_o=0, adr_o=ADR_STATUS for one cycle, then go to POLL_WT.
- POLL_WT: wait for ack_i and sample dat_i in the ack cycle.
  - bit0=1 -> WR_DAT.
  - bit0=0 -> GAP.
- GAP: count POLL_GAP cycles, then POLL_RD. Polling is unbounded while acks keep arriving.
- WR_DAT: drive stb_o=1, we_o=1, adr_o=ADR_DATA, dat_o=latched byte for one cycle, then go to WR_DAT_WT.
- WR_DAT_WT: on ack_i -> WR_GO.
- WR_GO: drive stb_o=1, we_o=1, adr_o=ADR_STATUS, dat_o=8'h01 for one cycle, then go to WR_GO_WT.
- WR_GO_WT: on ack_i -> IDLE.
- Bus rules:
  - stb_o is never high for two consecutive cycles.
  - adr_o, dat_o and we_o hold their values after the strobe until the next strobe.
  - ack_i is ignored outside the *_WT states.
  - An ack arriving in the same cycle as the strobe is not counted; only cycles after the strobe are.
- Timeout:
  - Each *_WT state counts cycles since the strobe.
  - If ACK_TIMEOUT cycles pass with no ack: set err_o, drop the byte, return to IDLE.
  - The pointer stays advanced, so the next requester goes first.
- err_o:
  - Set has priority over err_clr_i in the same cycle.
  - Otherwise err_clr_i clears err_o at the next edge.
- Minimum latency, grant to IDLE, with ack 2 cycles after each strobe and the UART idle on the first poll: 10 cycles.
- busy_o equals (state != IDLE). A requester that deasserts valid before being granted is simply skipped.

Test Plan:
- Single byte: req_valid_i=4'b0001, data 8'hAA; slave acks after 2 cycles and status returns 8'h01 -> req_ready_o[0] pulses once; bus shows read@ADR_STATUS, write 8'hAA@ADR_DATA, write 8'h01@ADR_STATUS, in that order; busy_o drops after 10 cycles; err_o=0.
- Round robin: all four valid, data 8'h10..8'h13, held until each ready pulse -> ADR_DATA writes occur in order 10,11,12,13. Re-assert requester 0 alone afterwards -> it is granted next.
- Busy UART: status reads 8'h00 three times, then 8'h01 -> exactly 4 status reads, each pair separated by POLL_GAP idle cycles, then the data write.
- Timeout: slave never acks the ADR_DATA write -> err_o=1 exactly ACK_TIMEOUT cycles after that strobe; FSM returns to IDLE; no start write is issued. Pulse err_clr_i -> err_o=0.
- Reset mid-operation: assert rst_n_i low during GAP -> all outputs go to 0 immediately. After release with requester 2 valid, requester 2 is served normally.
- Simultaneous: timeout set and err_clr_i in the same cycle -> err_o=1.
